// File: rtl/cve2_mem_resp_pkg.sv
// cve2_mem_resp_pkg
// Shared types and parameter legality helper for the cve2 memory responder.
//   mem_resp_entry_t : one in-flight response slot {valid, we, err, data}.
//   params_legal()   : true when RespLatency / NumOutstanding are usable.
package cve2_mem_resp_pkg;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic        err;
    logic [31:0] data;
  } mem_resp_entry_t;

  function automatic bit params_legal(int resp_latency, int num_outstanding);
    return (resp_latency >= 2) && (num_outstanding >= 1) &&
           (num_outstanding <= resp_latency);
  endfunction

endpackage

// File: rtl/cve2_mem_responder_if.sv
// cve2_mem_responder_if
// Core-side cve2 memory bus (req/gnt/rvalid handshake plus request and
// response fields).
//   master : core end (drives req, addr, we, be, wdata)
//   slave  : responder end (drives gnt, rvalid, rdata, err)
interface cve2_mem_responder_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, addr, we, be, wdata,
                  input  gnt, rvalid, rdata, err);
  modport slave  (input  req, addr, we, be, wdata,
                  output gnt, rvalid, rdata, err);
endinterface

// File: rtl/cve2_mem_resp_delay.sv
// cve2_mem_resp_delay
// Fixed-latency delay line of RespLatency-1 response slots. Slot 0 is loaded
// at the grant edge; slots shift every cycle and never stall. Backing read
// data (valid the cycle after the grant) is captured on the shift into
// slot 1. With RespLatency == 2 there is no slot 1, so the tail presents
// mem_rdata_i directly.
//   clk_i, rst_i  : clock, async active-high reset (clears all slots)
//   load_i        : entry written into slot 0 (valid = grant this cycle)
//   mem_rdata_i   : backing read data
//   tail_o        : final slot, data field already resolved
module cve2_mem_resp_delay
  import cve2_mem_resp_pkg::*;
#(
  parameter int RespLatency = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  mem_resp_entry_t load_i,
  input  logic [31:0]     mem_rdata_i,
  output mem_resp_entry_t tail_o
);

  localparam int Stages = RespLatency - 1;

  mem_resp_entry_t stage_q [Stages];
  mem_resp_entry_t stage_d [Stages];

  always_comb begin
    stage_d[0] = load_i;
    for (int i = 1; i < Stages; i++) begin
      stage_d[i] = stage_q[i-1];
      // Read data is only on the backing port during the cycle after grant.
      if (i == 1) stage_d[i].data = mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q <= stage_d;
    end
  end

  always_comb begin
    tail_o = stage_q[Stages-1];
    if (RespLatency == 2) tail_o.data = mem_rdata_i;
  end

endmodule

// File: rtl/cve2_mem_responder.sv
// cve2_mem_responder
// Memory-side end of the cve2 instruction/data interface. Grants requests
// (at most NumOutstanding in flight), forwards each to a single-cycle
// SRAM-style backing port and returns in-order responses exactly
// RespLatency cycles after the grant.
//   clk_i, rst_i       : clock, async active-high reset
//   bus                : cve2 bus, slave modport
//   stall_i            : inhibits new grants only
//   mem_req_o ..       : backing access, combinational copy of the request
//   mem_rdata_i        : backing read data, valid the cycle after mem_req_o
// Optional feature macro: CVE2_MEM_RESP_ERR_EN -- requests matching
// ErrBase/ErrMask are granted without a backing access and answer err_o=1.
module cve2_mem_responder
  import cve2_mem_resp_pkg::*;
#(
  parameter int          RespLatency    = 2,
  parameter int          NumOutstanding = 2,
  parameter logic [31:0] ErrBase        = 32'h0,
  parameter logic [31:0] ErrMask        = 32'h0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  cve2_mem_responder_if.slave  bus,
  input  logic                 stall_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [3:0]           mem_be_o,
  output logic [31:0]          mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic [31:0]          mem_rdata_i
);

  if (!params_legal(RespLatency, NumOutstanding)) begin : g_param_check
    $fatal(1, "cve2_mem_responder: illegal RespLatency/NumOutstanding");
  end

  localparam int              CntW   = $clog2(NumOutstanding + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(NumOutstanding);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rvalid_q, rvalid_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            gnt;
  logic            err_hit;
  mem_resp_entry_t load;
  mem_resp_entry_t tail;

`ifdef CVE2_MEM_RESP_ERR_EN
  assign err_hit = (ErrMask != '0) && ((bus.addr & ErrMask) == ErrBase);
`else
  logic unused_err_cfg;
  assign unused_err_cfg = ^{ErrBase, ErrMask};
  assign err_hit        = 1'b0;
`endif

  // A response retiring this cycle frees its slot for a same-cycle grant.
  assign gnt = bus.req & ~stall_i & ((cnt_q < CntMax) | rvalid_q);

  assign bus.gnt     = gnt;
  assign mem_req_o   = gnt & ~err_hit;
  assign mem_we_o    = bus.we;
  assign mem_be_o    = bus.be;
  assign mem_addr_o  = bus.addr;
  assign mem_wdata_o = bus.wdata;

  always_comb begin
    load       = '0;
    load.valid = gnt;
    load.we    = bus.we;
    load.err   = err_hit;
  end

  cve2_mem_resp_delay #(
    .RespLatency (RespLatency)
  ) u_delay (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (load),
    .mem_rdata_i (mem_rdata_i),
    .tail_o      (tail)
  );

  always_comb begin
    cnt_d = cnt_q;
    case ({gnt, rvalid_q})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    rvalid_d = tail.valid;
`ifdef CVE2_MEM_RESP_ERR_EN
    err_d    = tail.valid & tail.err;
`else
    err_d    = 1'b0;
`endif
    rdata_d  = (tail.valid & ~tail.we & ~tail.err) ? tail.data : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;
  assign bus.rdata  = rdata_q;

  cnt_max_a: assert property (@(posedge clk_i) disable iff (rst_i)
                              cnt_q <= CntMax);
  cnt_underflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
                                    !(rvalid_q && (cnt_q == '0)));

endmodule

// File: tb/tb_cve2_mem_responder.sv
module tb_cve2_mem_responder;

  localparam logic [31:0] EBASE = 32'hF000_0000;
  localparam logic [31:0] EMASK = 32'hF000_0000;
`ifdef CVE2_MEM_RESP_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cve2_mem_responder_if bus0();
  cve2_mem_responder_if bus1();

  logic        stall0, stall1;
  logic [31:0] mrd0, mrd1;
  wire         mreq0, mreq1, mwe0, mwe1;
  wire  [3:0]  mbe0, mbe1;
  wire  [31:0] maddr0, maddr1, mwdata0, mwdata1;

  cve2_mem_responder #(.RespLatency(2), .NumOutstanding(2),
                       .ErrBase(EBASE), .ErrMask(EMASK)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0), .stall_i(stall0),
    .mem_req_o(mreq0), .mem_we_o(mwe0), .mem_be_o(mbe0),
    .mem_addr_o(maddr0), .mem_wdata_o(mwdata0), .mem_rdata_i(mrd0));

  cve2_mem_responder #(.RespLatency(4), .NumOutstanding(2),
                       .ErrBase(EBASE), .ErrMask(EMASK)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1), .stall_i(stall1),
    .mem_req_o(mreq1), .mem_we_o(mwe1), .mem_be_o(mbe1),
    .mem_addr_o(maddr1), .mem_wdata_o(mwdata1), .mem_rdata_i(mrd1));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic gnt, rvalid, err, mreq, mwe;
    logic [3:0] mbe;
    logic [31:0] rdata, maddr, mwdata;
  } obs_t;

  typedef struct {
    logic req, stall, we;
    logic [3:0] be;
    logic [31:0] addr, wdata, mrdata;
    logic exp_gnt, exp_rvalid;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    int due;
    logic we, err;
    logic [31:0] data;
  } pend_t;

  pend_t q0[$];
  pend_t q1[$];
  logic [31:0] paddr[2];

  function automatic logic [31:0] datafn(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic int lat(int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic vec_t mk(logic req, logic stall, logic we, logic [3:0] be,
                              logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] mrdata, logic eg, logic ev,
                              logic [31:0] ed);
    vec_t v;
    v.req = req; v.stall = stall; v.we = we; v.be = be; v.addr = addr;
    v.wdata = wdata; v.mrdata = mrdata; v.exp_gnt = eg; v.exp_rvalid = ev;
    v.exp_rdata = ed;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(int k, logic req, logic stall, logic we, logic [3:0] be,
                       logic [31:0] addr, logic [31:0] wdata, logic [31:0] mrd);
    if (k == 0) begin
      bus0.req = req; bus0.we = we; bus0.be = be; bus0.addr = addr;
      bus0.wdata = wdata; stall0 = stall; mrd0 = mrd;
    end else begin
      bus1.req = req; bus1.we = we; bus1.be = be; bus1.addr = addr;
      bus1.wdata = wdata; stall1 = stall; mrd1 = mrd;
    end
  endtask

  task automatic idle(int k, logic [31:0] mrd);
    drive(k, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, mrd);
  endtask

  function automatic obs_t sample(int k);
    obs_t o;
    if (k == 0) begin
      o.gnt = bus0.gnt; o.rvalid = bus0.rvalid; o.err = bus0.err;
      o.rdata = bus0.rdata; o.mreq = mreq0; o.mwe = mwe0; o.mbe = mbe0;
      o.maddr = maddr0; o.mwdata = mwdata0;
    end else begin
      o.gnt = bus1.gnt; o.rvalid = bus1.rvalid; o.err = bus1.err;
      o.rdata = bus1.rdata; o.mreq = mreq1; o.mwe = mwe1; o.mbe = mbe1;
      o.maddr = maddr1; o.mwdata = mwdata1;
    end
    return o;
  endfunction

  // Reference model: pending responses queued with their due cycle.
  task automatic model_check(int k, logic req, logic stall, logic we,
                             logic [3:0] be, logic [31:0] addr,
                             logic [31:0] wdata);
    pend_t front;
    pend_t p;
    obs_t  o;
    int    sz;
    bit    due, eg, hit;
    sz  = (k == 0) ? q0.size() : q1.size();
    due = 1'b0;
    front = '{due: 0, we: 1'b0, err: 1'b0, data: 32'h0};
    if (sz > 0) begin
      front = (k == 0) ? q0[0] : q1[0];
      due   = (front.due == cyc);
    end
    eg  = req && !stall && ((sz < 2) || due);
    hit = ERR_ON && ((addr & EMASK) == EBASE);
    o   = sample(k);
    chk("rnd_gnt", o.gnt, eg);
    chk("rnd_mem_req", o.mreq, eg && !hit);
    chk("rnd_mem_we", o.mwe, we);
    chk("rnd_mem_be", o.mbe, be);
    chk("rnd_mem_addr", o.maddr, addr);
    chk("rnd_mem_wdata", o.mwdata, wdata);
    chk("rnd_rvalid", o.rvalid, due);
    chk("rnd_err", o.err, due && front.err);
    chk("rnd_rdata", o.rdata, (due && !front.we && !front.err) ? front.data : 32'h0);
    if (due) begin
      if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
    if (eg) begin
      p.due = cyc + lat(k); p.we = we; p.err = hit; p.data = datafn(addr);
      if (k == 0) q0.push_back(p); else q1.push_back(p);
    end
  endtask

  initial begin
    vec_t  tbl[19];
    obs_t  o;
    int    gc[$];
    int    rc[$];
    int    exp_g[6];
    int    exp_r[6];
    logic  rq[2], st[2], we[2];
    logic [3:0]  be[2];
    logic [31:0] ad[2], wd[2], md[2];

    tbl[0]  = mk(0,0,0,4'h0,32'h0,        32'h0,        32'h0,        0,0,32'h0);
    tbl[1]  = mk(1,0,0,4'hF,32'h100,      32'h0,        32'h0,        1,0,32'h0);
    tbl[2]  = mk(0,0,0,4'h0,32'h0,        32'h0,        32'hDEADBEEF, 0,0,32'h0);
    tbl[3]  = mk(0,0,0,4'h0,32'h0,        32'h0,        32'h0,        0,1,32'hDEADBEEF);
    tbl[4]  = mk(1,0,1,4'h3,32'h200,      32'h12345678, 32'h0,        1,0,32'h0);
    tbl[5]  = mk(0,0,0,4'h0,32'h0,        32'h0,        32'hAAAA5555, 0,0,32'h0);
    tbl[6]  = mk(0,0,0,4'h0,32'h0,        32'h0,        32'h0,        0,1,32'h0);
    tbl[7]  = mk(1,1,0,4'hF,32'h300,      32'h0,        32'h0,        0,0,32'h0);
    tbl[8]  = mk(1,1,0,4'hF,32'h300,      32'h0,        32'h0,        0,0,32'h0);
    tbl[9]  = mk(1,1,0,4'hF,32'h300,      32'h0,        32'h0,        0,0,32'h0);
    tbl[10] = mk(1,0,0,4'hF,32'h300,      32'h0,        32'h0,        1,0,32'h0);
    tbl[11] = mk(0,0,0,4'h0,32'h0,        32'h0,        32'h0BADF00D, 0,0,32'h0);
    tbl[12] = mk(0,0,0,4'h0,32'h0,        32'h0,        32'h0,        0,1,32'h0BADF00D);
    tbl[13] = mk(1,0,0,4'hF,32'h400,      32'h0,        32'h0,        1,0,32'h0);
    tbl[14] = mk(1,0,0,4'hF,32'h404,      32'h0,        32'h11111111, 1,0,32'h0);
    tbl[15] = mk(1,0,0,4'hF,32'h408,      32'h0,        32'h22222222, 1,1,32'h11111111);
    tbl[16] = mk(0,0,0,4'h0,32'h0,        32'h0,        32'h33333333, 0,1,32'h22222222);
    tbl[17] = mk(0,0,0,4'h0,32'h0,        32'h0,        32'h0,        0,1,32'h33333333);
    tbl[18] = mk(0,0,0,4'h0,32'h0,        32'h0,        32'h0,        0,0,32'h0);
    exp_g = '{0, 1, 4, 5, 8, 9};
    exp_r = '{4, 5, 8, 9, 12, 13};

    // Reset state
    idle(0, 32'h0); idle(1, 32'h0);
    rst = 1'b1;
    repeat (2) step();
    #1;
    for (int k = 0; k < 2; k++) begin
      o = sample(k);
      chk("rst_rvalid", o.rvalid, 1'b0);
      chk("rst_err", o.err, 1'b0);
      chk("rst_rdata", o.rdata, 32'h0);
      chk("rst_mem_req", o.mreq, 1'b0);
    end
    step(); rst = 1'b0;

    // Directed table on the RespLatency=2 instance
    for (int i = 0; i < 19; i++) begin
      step();
      drive(0, tbl[i].req, tbl[i].stall, tbl[i].we, tbl[i].be, tbl[i].addr,
            tbl[i].wdata, tbl[i].mrdata);
      idle(1, 32'h0);
      #1;
      o = sample(0);
      chk($sformatf("tbl%0d_gnt", i), o.gnt, tbl[i].exp_gnt);
      chk($sformatf("tbl%0d_mem_req", i), o.mreq, tbl[i].exp_gnt);
      chk($sformatf("tbl%0d_mem_we", i), o.mwe, tbl[i].we);
      chk($sformatf("tbl%0d_mem_be", i), o.mbe, tbl[i].be);
      chk($sformatf("tbl%0d_mem_addr", i), o.maddr, tbl[i].addr);
      chk($sformatf("tbl%0d_mem_wdata", i), o.mwdata, tbl[i].wdata);
      chk($sformatf("tbl%0d_rvalid", i), o.rvalid, tbl[i].exp_rvalid);
      chk($sformatf("tbl%0d_rdata", i), o.rdata, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_err", i), o.err, 1'b0);
    end

    // RespLatency=4, NumOutstanding=2: six reads with req held
    for (int t = 0; t < 16; t++) begin
      step();
      idle(0, 32'h0);
      drive(1, (gc.size() < 6), 1'b0, 1'b0, 4'hF, 32'h500, 32'h0, datafn(32'h500));
      #1;
      o = sample(1);
      if (o.gnt) gc.push_back(t);
      if (o.rvalid) begin
        rc.push_back(t);
        chk("l4_rdata", o.rdata, datafn(32'h500));
      end
    end
    chk("l4_num_gnt", gc.size(), 6);
    chk("l4_num_rvalid", rc.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("l4_gnt_cycle%0d", i), (i < gc.size()) ? gc[i] : -1, exp_g[i]);
      chk($sformatf("l4_rvalid_cycle%0d", i), (i < rc.size()) ? rc[i] : -1, exp_r[i]);
    end

    // Reset in the middle of a transaction
    step(); idle(0, 32'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 4'hF, 32'h600, 32'h0, 32'h0);
    #1; chk("mrst_gnt", bus1.gnt, 1'b1);
    step(); rst = 1'b1; idle(1, 32'h55555555);
    #1; chk("mrst_rvalid_a", bus1.rvalid, 1'b0);
    step(); idle(1, 32'h0);
    #1; chk("mrst_rvalid_b", bus1.rvalid, 1'b0);
    chk("mrst_cnt", 32'(dut1.cnt_q), 32'h0);
    step(); rst = 1'b0;
    #1; chk("mrst_rvalid_c", bus1.rvalid, 1'b0);
    step(); drive(1, 1'b1, 1'b0, 1'b0, 4'hF, 32'h604, 32'h0, 32'h0);
    #1; chk("mrst_regrant", bus1.gnt, 1'b1);
    chk("mrst_rvalid_d", bus1.rvalid, 1'b0);
    for (int t = 0; t < 3; t++) begin
      step(); idle(1, (t == 0) ? 32'h77777777 : 32'h0);
      #1; chk("mrst_rvalid_wait", bus1.rvalid, 1'b0);
    end
    step(); idle(1, 32'h0);
    #1; chk("mrst_resp_rvalid", bus1.rvalid, 1'b1);
    chk("mrst_resp_rdata", bus1.rdata, 32'h77777777);

`ifdef CVE2_MEM_RESP_ERR_EN
    // Error region read: no backing access, err response at N+2
    step(); drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 32'hF000_0010, 32'h0, 32'h0);
    #1; chk("err_gnt", bus0.gnt, 1'b1);
    chk("err_mem_req", mreq0, 1'b0);
    step(); idle(0, 32'hFFFFFFFF);
    #1; chk("err_rvalid_early", bus0.rvalid, 1'b0);
    step(); idle(0, 32'h0);
    #1; chk("err_rvalid", bus0.rvalid, 1'b1);
    chk("err_err", bus0.err, 1'b1);
    chk("err_rdata", bus0.rdata, 32'h0);
`endif

    // Randomized phase against the queue model
    step(); rst = 1'b1; idle(0, 32'h0); idle(1, 32'h0);
    step(); rst = 1'b0;
    q0.delete(); q1.delete();
    paddr[0] = 32'h0; paddr[1] = 32'h0;
    for (int t = 0; t < 600; t++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        rq[k] = ($urandom_range(0, 9) < 7);
        st[k] = ($urandom_range(0, 4) == 0);
        we[k] = $urandom_range(0, 1) == 1;
        be[k] = 4'($urandom);
        ad[k] = ($urandom_range(0, 7) == 0) ? {24'hF00000, 8'($urandom)}
                                            : ($urandom & 32'hFFFF_FFFC);
        wd[k] = $urandom;
        md[k] = datafn(paddr[k]);
        paddr[k] = ad[k];
        drive(k, rq[k], st[k], we[k], be[k], ad[k], wd[k], md[k]);
      end
      #1;
      for (int k = 0; k < 2; k++) model_check(k, rq[k], st[k], we[k], be[k], ad[k], wd[k]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
